sopc_multi_timer: RTL and testbench
===================================

# sopc_multi_timer

Multi-channel, parametrised Avalon-MM interval timer for the SOPC system, and the successor to the single 32-bit system clock timer. Each of NUM_CH independent channels has its own down-counter of COUNTER_WIDTH bits, a programmable clock prescaler, a period register, a snapshot register, and one-shot or continuous mode. A single combined interrupt line and a pending-interrupt summary register allow one ISR to service all channels.

## Interface
- NUM_CH, 2: number of timer channels, 1..8
- CH_AW, 1: channel-select address bits, ceil(log2(NUM_CH)), minimum 1
- COUNTER_WIDTH, 32: counter and period width, 17..32
- RESET_PERIOD, 49999: reset value of every period register and counter
- clk  in  1  system clock; the only clock
- reset_n  in  1  asynchronous active-low reset
- address  in  CH_AW+3  {channel, register}; register field is address[2:0]
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe; a write is chipselect && !write_n
- writedata  in  16  write data
- readdata  out  16  registered read data; reset value 0
- irq  out  1  OR of all channel interrupts; reset value 0

## Operation
- Register map per channel:
  - 0 STATUS: read {RUN, TO}; any write clears TO.
  - 1 CONTROL: bits [3:0] = STOP, START, CONT, ITO. Read returns the stored 4 bits. START and STOP are also one-cycle command strobes.
  - 2 PERIOD_L: bits [15:0].
  - 3 PERIOD_H: bits [COUNTER_WIDTH-1:16]; unused bits are read as 0.
  - 4 SNAP_L and 5 SNAP_H: writing either captures the live counter into the snapshot; reads return snapshot halves.
  - 6 PRESCALE: 16-bit divider value P; the channel ticks once every P+1 clocks.
  - 7 IRQ_PEND: read-only, the same value in every channel. Bit n is irq_n; upper bits are 0. Writes are ignored.
- Address with channel ≥ NUM_CH: reads return 0 and writes are ignored.
- Prescaler: a 16-bit counter per channel, running only while RUN=1. When it reaches P, it wraps to 0 and asserts tick for one cycle. It clears to 0 on START, on a PRESCALE write, and on stop.
- On each tick while RUN=1:
  - If the counter is not 0, the counter decrements.
  - If the counter is 0, the counter reloads the period, TO is set, and RUN clears if CONT=0.
  - A period value V therefore gives a timeout every (V+1)·(P+1) clocks.
- A write to PERIOD_L or PERIOD_H sets force_reload on the next cycle. On that cycle the counter loads the full period and RUN clears. Software must issue START again.
- START while stopped sets RUN. The counter resumes from its current value; it does not reload.
- irq_n = TO_n && ITO_n; irq = OR over all n.
- Reset: counters and periods = RESET_PERIOD; prescale, control, TO, RUN, snapshot, readdata all 0.

## Timing
- Register writes take effect on the clock edge of the write cycle.
- readdata is valid on the cycle after address/chipselect (latency 1). Reads have no side effects.
- START strobe at edge k: RUN=1 after edge k. The first tick occurs at edge k+1+P.
- Timeout tick at edge t: TO=1 and irq=1 (if ITO) after edge t. The counter equals the period after edge t.
- Simultaneous events, per channel:
  - START and STOP in one write: START wins.
  - STATUS write and timeout in the same cycle: TO ends at 1 (set wins; no lost events).
  - Period write and timeout tick in the same cycle: the tick is processed. force_reload follows on the next cycle.
  - Snapshot write in the same cycle as a decrement: the pre-decrement value is captured.
- Channels are fully independent. A write addresses exactly one channel.
- reset_n asserted mid-count: all state returns to reset values immediately (asynchronously). Operation restarts only after an explicit START.

## Test plan
- Reset then read: channel 0 PERIOD_L reads 49999 (0xC34F), PERIOD_H reads 0, STATUS reads 0, irq=0, readdata latency exactly 1 cycle.
- Continuous mode:
  - Stimulus: ch1 PERIOD=9, PRESCALE=0, CONTROL=0b0111.
  - Response: TO and irq rise every 10 clocks. A STATUS write clears TO. IRQ_PEND reads 0b10.
- Prescaler with one-shot:
  - Stimulus: ch0 PERIOD=3, PRESCALE=4, CONTROL=0b0101.
  - Response: a single timeout 20 clocks after START, then RUN=0 and the counter holds 3.
- Period write mid-count:
  - Stimulus: while running, write PERIOD_L=100.
  - Response: on the next cycle the counter is 100 and RUN=0. A following START resumes the count from 100.
- Collisions:
  - STATUS write on the timeout cycle: TO=1.
  - CONTROL=0b1100: RUN=1.
  - SNAP_L write while counting from 50: SNAP_L reads 50.
- COUNTER_WIDTH=24, NUM_CH=3:
  - Stimulus: PERIOD_H write 0xFFFF.
  - Response: PERIOD_H reads 0x00FF. Channel-3 address reads 0, and writes to it change nothing.

Source files
------------

// File: rtl/sopc_multi_timer.sv
// sopc_multi_timer: NUM_CH independent Avalon-MM interval timers, each with a
// prescaler, period, snapshot and one-shot/continuous mode, sharing one irq line.
module sopc_multi_timer #(
  parameter int NUM_CH        = 2,
  parameter int CH_AW         = 1,
  parameter int COUNTER_WIDTH = 32,
  parameter int RESET_PERIOD  = 49999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [CH_AW+2:0] address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [15:0]      writedata,
  output logic [15:0]      readdata,
  output logic             irq
);

  localparam int CW = COUNTER_WIDTH;
  localparam int HW = CW - 16;

  typedef enum logic [2:0] {
    REG_STATUS   = 3'd0,
    REG_CONTROL  = 3'd1,
    REG_PERIOD_L = 3'd2,
    REG_PERIOD_H = 3'd3,
    REG_SNAP_L   = 3'd4,
    REG_SNAP_H   = 3'd5,
    REG_PRESCALE = 3'd6,
    REG_IRQ_PEND = 3'd7
  } reg_e;

  // CONTROL bit positions: {STOP, START, CONT, ITO}
  localparam int C_ITO  = 0;
  localparam int C_CONT = 1;

  logic [CW-1:0]     r_counter  [NUM_CH];
  logic [CW-1:0]     r_period   [NUM_CH];
  logic [CW-1:0]     r_snap     [NUM_CH];
  logic [15:0]       r_prescale [NUM_CH];
  logic [15:0]       r_pcnt     [NUM_CH];
  logic [3:0]        r_ctrl     [NUM_CH];
  logic [NUM_CH-1:0] r_to;
  logic [NUM_CH-1:0] r_run;
  logic [NUM_CH-1:0] r_force_reload;
  logic [15:0]       r_readdata;

  logic              w_wr;
  logic [CH_AW-1:0]  w_ch;
  reg_e              w_reg;
  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_tick;
  logic [NUM_CH-1:0] w_timeout;
  logic [NUM_CH-1:0] w_start;
  logic [NUM_CH-1:0] w_stop;
  logic [NUM_CH-1:0] w_irq_pend;
  logic [15:0]       w_rdata;

  assign w_wr  = chipselect && !write_n;
  assign w_ch  = address[CH_AW+2:3];
  assign w_reg = reg_e'(address[2:0]);

  // A channel address >= NUM_CH matches no channel, so such writes fall away.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // assignment so no path can leave it holding state (no inferred latch).
    w_sel      = '0;
    w_tick     = '0;
    w_timeout  = '0;
    w_start    = '0;
    w_stop     = '0;
    w_irq_pend = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_sel[c]      = w_wr && (w_ch == CH_AW'(c));
      w_tick[c]     = r_run[c] && (r_pcnt[c] == r_prescale[c]);
      w_timeout[c]  = w_tick[c] && (r_counter[c] == '0);
      w_start[c]    = w_sel[c] && (w_reg == REG_CONTROL) && writedata[2];
      w_stop[c]     = w_sel[c] && (w_reg == REG_CONTROL) && writedata[3] && !writedata[2];
      w_irq_pend[c] = r_to[c] && r_ctrl[c][C_ITO];
    end
  end

  assign irq = |w_irq_pend;

  always_comb begin
    w_rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (chipselect && (w_ch == CH_AW'(c))) begin
        case (w_reg)
          REG_STATUS:   w_rdata = {14'd0, r_run[c], r_to[c]};
          REG_CONTROL:  w_rdata = {12'd0, r_ctrl[c]};
          REG_PERIOD_L: w_rdata = r_period[c][15:0];
          REG_PERIOD_H: w_rdata = 16'(r_period[c][CW-1:16]);
          REG_SNAP_L:   w_rdata = r_snap[c][15:0];
          REG_SNAP_H:   w_rdata = 16'(r_snap[c][CW-1:16]);
          REG_PRESCALE: w_rdata = r_prescale[c];
          REG_IRQ_PEND: w_rdata = 16'(w_irq_pend);
          default:      w_rdata = '0;
        endcase
      end
    end
  end

  assign readdata = r_readdata;

  // NOTE: all state here is plain flops (no RAM), so every array element is
  // cleared by the asynchronous reset loop; sequential state uses <= only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_counter[c]  <= CW'(RESET_PERIOD);
        r_period[c]   <= CW'(RESET_PERIOD);
        r_snap[c]     <= '0;
        r_prescale[c] <= '0;
        r_pcnt[c]     <= '0;
        r_ctrl[c]     <= '0;
      end
      r_to           <= '0;
      r_run          <= '0;
      r_force_reload <= '0;
      r_readdata     <= '0;
    end else begin
      r_readdata <= w_rdata;
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_sel[c]) begin
          case (w_reg)
            REG_CONTROL:  r_ctrl[c]              <= writedata[3:0];
            REG_PERIOD_L: r_period[c][15:0]      <= writedata;
            REG_PERIOD_H: r_period[c][CW-1:16]   <= writedata[HW-1:0];
            REG_SNAP_L,
            REG_SNAP_H:   r_snap[c]              <= r_counter[c];
            REG_PRESCALE: r_prescale[c]          <= writedata;
            default:      ;
          endcase
        end

        r_force_reload[c] <= w_sel[c] &&
                             ((w_reg == REG_PERIOD_L) || (w_reg == REG_PERIOD_H));

        // A timeout in the same cycle as a STATUS write must not be lost.
        if (w_timeout[c])
          r_to[c] <= 1'b1;
        else if (w_sel[c] && (w_reg == REG_STATUS))
          r_to[c] <= 1'b0;

        if (r_force_reload[c])
          r_counter[c] <= r_period[c];
        else if (w_timeout[c])
          r_counter[c] <= r_period[c];
        else if (w_tick[c])
          r_counter[c] <= r_counter[c] - CW'(1);

        if (r_force_reload[c])
          r_run[c] <= 1'b0;
        else if (w_start[c])
          r_run[c] <= 1'b1;
        else if (w_stop[c])
          r_run[c] <= 1'b0;
        else if (w_timeout[c] && !r_ctrl[c][C_CONT])
          r_run[c] <= 1'b0;

        // Prescaler sits at 0 whenever stopped, so a stop also clears it.
        if (w_start[c] || !r_run[c] || w_tick[c] ||
            (w_sel[c] && (w_reg == REG_PRESCALE)))
          r_pcnt[c] <= '0;
        else
          r_pcnt[c] <= r_pcnt[c] + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sopc_multi_timer.sv
// Self-checking bench for sopc_multi_timer: register table, timed sequences,
// randomized period/prescale timing and a randomized register model.
module tb_sopc_multi_timer;

  localparam int RP = 49999;
  localparam int R_STATUS = 0, R_CONTROL = 1, R_PER_L = 2, R_PER_H = 3;
  localparam int R_SNAP_L = 4, R_SNAP_H = 5, R_PRESC = 6, R_PEND = 7;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  a0  = '0;
  logic        cs0 = 1'b0;
  logic        wn0 = 1'b1;
  logic [15:0] wd0 = '0;
  logic [15:0] rd0;
  logic        irq0;
  logic [4:0]  a3  = '0;
  logic        cs3 = 1'b0;
  logic        wn3 = 1'b1;
  logic [15:0] wd3 = '0;
  logic [15:0] rd3;
  logic        irq3;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sopc_multi_timer #(.NUM_CH(2), .CH_AW(1), .COUNTER_WIDTH(32), .RESET_PERIOD(RP)) dut (
    .clk(clk), .reset_n(reset_n), .address(a0), .chipselect(cs0), .write_n(wn0),
    .writedata(wd0), .readdata(rd0), .irq(irq0));

  sopc_multi_timer #(.NUM_CH(3), .CH_AW(2), .COUNTER_WIDTH(24), .RESET_PERIOD(RP)) dut3 (
    .clk(clk), .reset_n(reset_n), .address(a3), .chipselect(cs3), .write_n(wn3),
    .writedata(wd3), .readdata(rd3), .irq(irq3));

  typedef struct {
    int          ch;
    int          r;
    bit          we;
    logic [15:0] d;
    logic [15:0] exp;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; one bus cycle; returns at the next negedge.
  task automatic xfer(input bit d3, input int ch, input int r, input bit we,
                      input logic [15:0] d, output logic [15:0] q);
    if (!d3) begin
      a0 = 4'(ch * 8 + r); cs0 = 1'b1; wn0 = !we; wd0 = d;
    end else begin
      a3 = 5'(ch * 8 + r); cs3 = 1'b1; wn3 = !we; wd3 = d;
    end
    @(negedge clk);
    cs0 = 1'b0; wn0 = 1'b1; cs3 = 1'b0; wn3 = 1'b1;
    q = d3 ? rd3 : rd0;
  endtask

  task automatic wr(input int ch, input int r, input logic [15:0] d);
    logic [15:0] q;
    xfer(1'b0, ch, r, 1'b1, d, q);
  endtask

  task automatic rd(input int ch, input int r, output logic [15:0] q);
    xfer(1'b0, ch, r, 1'b0, 16'd0, q);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int edge_no);
    while (cyc < edge_no) @(negedge clk);
  endtask

  // Returns the clock edge after which irq0 was first seen high, or -1.
  task automatic wait_irq(input int limit, output int e);
    e = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (irq0) begin
        e = cyc;
        break;
      end
    end
  endtask

  task automatic add(inout vec_t tbl[$], input int ch, input int r, input bit we,
                     input logic [15:0] d, input logic [15:0] exp, input string name);
    vec_t v;
    v.ch = ch; v.r = r; v.we = we; v.d = d; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask

  initial begin
    vec_t        tbl[$];
    logic [15:0] q;
    int          k, e, e2, k0, k1, k2, s2, rem, v, p, t;
    logic [23:0] m_per [3];
    logic [15:0] m_pre [3];
    logic [3:0]  m_ctl [3];
    int          wregs [4];
    int          rregs [6];

    add(tbl, 0, R_PER_L,  0, 0, 16'hC34F, "rst_per_l");
    add(tbl, 0, R_PER_H,  0, 0, 16'h0000, "rst_per_h");
    add(tbl, 0, R_STATUS, 0, 0, 16'h0000, "rst_status");
    add(tbl, 0, R_CONTROL,0, 0, 16'h0000, "rst_control");
    add(tbl, 0, R_PRESC,  0, 0, 16'h0000, "rst_prescale");
    add(tbl, 0, R_SNAP_L, 0, 0, 16'h0000, "rst_snap_l");
    add(tbl, 1, R_PER_L,  0, 0, 16'hC34F, "rst_ch1_per_l");
    add(tbl, 1, R_PEND,   0, 0, 16'h0000, "rst_irq_pend");
    add(tbl, 0, R_PRESC,  1, 16'hA5A5, 0, "");
    add(tbl, 0, R_PRESC,  0, 0, 16'hA5A5, "prescale_rb");
    add(tbl, 1, R_CONTROL,1, 16'h0003, 0, "");
    add(tbl, 1, R_CONTROL,0, 0, 16'h0003, "control_rb");
    add(tbl, 1, R_STATUS, 0, 0, 16'h0000, "no_start_status");
    add(tbl, 1, R_PER_H,  1, 16'h1234, 0, "");
    add(tbl, 1, R_PER_H,  0, 0, 16'h1234, "per_h_rb");
    add(tbl, 1, R_PER_L,  0, 0, 16'hC34F, "per_l_kept");
    add(tbl, 1, R_SNAP_H, 1, 16'h0000, 0, "");
    add(tbl, 1, R_SNAP_H, 0, 0, 16'h1234, "snap_h_reload");
    add(tbl, 1, R_SNAP_L, 0, 0, 16'hC34F, "snap_l_reload");
    add(tbl, 1, R_PEND,   1, 16'hFFFF, 0, "");
    add(tbl, 0, R_PEND,   0, 0, 16'h0000, "pend_write_ignored");
    add(tbl, 0, R_PRESC,  1, 16'h0000, 0, "");
    add(tbl, 1, R_CONTROL,1, 16'h0000, 0, "");
    add(tbl, 1, R_PER_H,  1, 16'h0000, 0, "");

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_irq", irq0, 0);
    check("rst_readdata", rd0, 0);

    // Read latency: nothing visible combinationally, data after one edge.
    a0 = 4'(R_PER_L); cs0 = 1'b1; wn0 = 1'b1;
    #1 check("latency_pre", rd0, 0);
    @(negedge clk);
    cs0 = 1'b0;
    check("latency_one", rd0, 16'hC34F);

    foreach (tbl[i]) begin
      xfer(1'b0, tbl[i].ch, tbl[i].r, tbl[i].we, tbl[i].d, q);
      if (!tbl[i].we) check(tbl[i].name, q, tbl[i].exp);
    end

    // Continuous mode on ch1: period 9, no prescale -> timeout every 10 clocks.
    wr(1, R_PER_H, 0); wr(1, R_PER_L, 9); wr(1, R_PRESC, 0); wr(1, R_STATUS, 0);
    wr(1, R_CONTROL, 16'h7); k = cyc;
    wait_irq(50, e);
    check("cont_first_to", e, k + 10);
    wr(1, R_STATUS, 0);
    check("cont_to_cleared", irq0, 0);
    wait_irq(50, e2);
    check("cont_second_to", e2, k + 20);
    rd(0, R_PEND, q);
    check("irq_pend_ch0", q, 16'h0002);
    wr(1, R_STATUS, 0);
    wait_until(k + 29);
    wr(1, R_STATUS, 0);
    check("status_wr_vs_to_irq", irq0, 1);
    rd(1, R_STATUS, q);
    check("status_wr_vs_to", q, 16'h0003);
    wr(1, R_CONTROL, 16'h8); wr(1, R_STATUS, 0);
    check("ch1_stopped_irq", irq0, 0);

    // One-shot on ch0 with prescale 4: single timeout 20 clocks after START.
    wr(0, R_PER_L, 3); wr(0, R_PER_H, 0); wr(0, R_PRESC, 4); wr(0, R_STATUS, 0);
    wr(0, R_CONTROL, 16'h5); k = cyc;
    wait_irq(100, e);
    check("oneshot_to_edge", e, k + 20);
    rd(0, R_STATUS, q);
    check("oneshot_status", q, 16'h0001);
    wr(0, R_SNAP_L, 0);
    rd(0, R_SNAP_L, q);
    check("oneshot_counter_hold", q, 3);
    wr(0, R_STATUS, 0);
    idle(40);
    check("oneshot_single", irq0, 0);
    rd(0, R_STATUS, q);
    check("oneshot_stays_stopped", q, 0);

    // Period write mid-count: reload and stop exactly one cycle later.
    wr(0, R_PER_L, 1000); wr(0, R_PRESC, 0); wr(0, R_CONTROL, 16'h4);
    idle(5);
    wr(0, R_PER_L, 100);
    rd(0, R_STATUS, q);
    check("pw_still_running", q, 16'h0002);
    rd(0, R_STATUS, q);
    check("pw_run_cleared", q, 0);
    wr(0, R_SNAP_L, 0);
    rd(0, R_SNAP_L, q);
    check("pw_counter_reload", q, 100);

    // START resumes from the current count after a STOP.
    wr(0, R_CONTROL, 16'h4); k0 = cyc;
    idle(6);
    wr(0, R_CONTROL, 16'h8); k1 = cyc;
    rem = 100 - (k1 - k0);
    wr(0, R_SNAP_L, 0);
    rd(0, R_SNAP_L, q);
    check("stop_hold", q, 16'(rem));
    idle(3);
    wr(0, R_CONTROL, 16'h4); k2 = cyc;
    idle(4);
    wr(0, R_SNAP_L, 0); s2 = cyc;
    rd(0, R_SNAP_L, q);
    check("start_resume", q, 16'(rem - (s2 - 1 - k2)));
    wr(0, R_CONTROL, 16'h8);

    // START and STOP together: START wins.
    wr(0, R_CONTROL, 16'hC);
    rd(0, R_STATUS, q);
    check("start_beats_stop", q, 16'h0002);
    wr(0, R_CONTROL, 16'h8);

    // Snapshot on the same edge as a decrement captures the old value.
    wr(0, R_PER_L, 50); wr(0, R_PRESC, 0); wr(0, R_CONTROL, 16'h4);
    wr(0, R_SNAP_L, 0);
    rd(0, R_SNAP_L, q);
    check("snap_pre_decrement", q, 50);
    rd(0, R_SNAP_H, q);
    check("snap_h_zero", q, 0);
    wr(0, R_CONTROL, 16'h8);

    // Randomized period/prescale: timeouts at START + n*(V+1)*(P+1).
    for (int it = 0; it < 5; it++) begin
      v = $urandom_range(6, 2);
      p = $urandom_range(3, 0);
      t = (v + 1) * (p + 1);
      wr(1, R_CONTROL, 16'h8); wr(1, R_PRESC, 16'(p)); wr(1, R_PER_L, 16'(v));
      wr(1, R_PER_H, 0); wr(1, R_STATUS, 0);
      wr(1, R_CONTROL, 16'h7); k = cyc;
      wait_irq(200, e);
      check($sformatf("rand_to1_v%0d_p%0d", v, p), e, k + t);
      wr(1, R_SNAP_L, 0);
      wr(1, R_STATUS, 0);
      wait_irq(200, e2);
      check($sformatf("rand_to2_v%0d_p%0d", v, p), e2, k + 2 * t);
      rd(1, R_SNAP_L, q);
      check($sformatf("rand_reload_v%0d", v), q, 16'(v));
    end
    wr(1, R_CONTROL, 16'h8); wr(1, R_STATUS, 0);

    // 24-bit, 3-channel instance: randomized register model incl. channel 3.
    wregs = '{R_CONTROL, R_PER_L, R_PER_H, R_PRESC};
    rregs = '{R_STATUS, R_CONTROL, R_PER_L, R_PER_H, R_PRESC, R_PEND};
    for (int c = 0; c < 3; c++) begin
      m_per[c] = 24'(RP); m_pre[c] = '0; m_ctl[c] = '0;
    end
    xfer(1'b1, 0, R_PER_H, 1'b1, 16'hFFFF, q);
    m_per[0][23:16] = 8'hFF;
    xfer(1'b1, 0, R_PER_H, 1'b0, 16'h0, q);
    check("w24_per_h_mask", q, 16'h00FF);
    xfer(1'b1, 3, R_PER_L, 1'b1, 16'h1234, q);
    xfer(1'b1, 3, R_PER_L, 1'b0, 16'h0, q);
    check("ch3_read_zero", q, 0);
    for (int c = 0; c < 3; c++) begin
      xfer(1'b1, c, R_PER_L, 1'b0, 16'h0, q);
      check($sformatf("ch3_write_ignored_%0d", c), q, m_per[c][15:0]);
    end
    for (int it = 0; it < 40; it++) begin
      int          wc, wrg, rc, rrg;
      logic [15:0] d, ex;
      wc  = $urandom_range(3, 0);
      wrg = wregs[$urandom_range(3, 0)];
      d   = 16'($urandom);
      if (wrg == R_CONTROL) d[2] = 1'b0;
      xfer(1'b1, wc, wrg, 1'b1, d, q);
      if (wc < 3) begin
        case (wrg)
          R_CONTROL: m_ctl[wc] = d[3:0];
          R_PER_L:   m_per[wc][15:0] = d;
          R_PER_H:   m_per[wc][23:16] = d[7:0];
          default:   m_pre[wc] = d;
        endcase
      end
      rc  = $urandom_range(3, 0);
      rrg = rregs[$urandom_range(5, 0)];
      xfer(1'b1, rc, rrg, 1'b0, 16'h0, q);
      ex = '0;
      if (rc < 3) begin
        case (rrg)
          R_CONTROL: ex = {12'd0, m_ctl[rc]};
          R_PER_L:   ex = m_per[rc][15:0];
          R_PER_H:   ex = {8'd0, m_per[rc][23:16]};
          R_PRESC:   ex = m_pre[rc];
          default:   ex = '0;
        endcase
      end
      check($sformatf("rand3_ch%0d_r%0d", rc, rrg), q, ex);
    end
    check("w24_irq_quiet", irq3, 0);

    // Asynchronous reset mid-count, then no automatic restart.
    wr(1, R_PRESC, 0); wr(1, R_PER_L, 9); wr(1, R_STATUS, 0); wr(1, R_CONTROL, 16'h7);
    idle(15);
    check("pre_reset_irq", irq0, 1);
    a0 = 4'(1 * 8 + R_PER_L); cs0 = 1'b1; wn0 = 1'b1;
    @(negedge clk);
    check("pre_reset_read", rd0, 9);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_irq", irq0, 0);
    check("async_reset_readdata", rd0, 0);
    cs0 = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd(1, R_PER_L, q);
    check("post_reset_period", q, 16'hC34F);
    rd(1, R_STATUS, q);
    check("post_reset_status", q, 0);
    idle(30);
    check("post_reset_no_restart", irq0, 0);
    rd(1, R_CONTROL, q);
    check("post_reset_control", q, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
